// File: rtl/rv32_pkg.sv
// Shared RV32I encodings, datapath select types and multicycle-control constants.
// Imported by the multicycle control FSM and its EXEC-phase decoder.
package rv32_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;

  typedef logic [2:0] funct3_t;

  typedef enum logic {
    PC_PC4 = 1'b0,
    PC_ALU = 1'b1
  } PCSel_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } ImmSel_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } ALUSel_t;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } WBSel_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } mc_state_t;

  localparam int MC_TO_DEFAULT = 255;
  localparam int MC_CNT_MIN_W  = 8;

  function automatic logic is_legal_opcode(input opcode_t op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // funct3[2] picks the less-than comparator, funct3[0] inverts the sense.
  function automatic logic branch_taken(input funct3_t f3, input logic br_eq,
                                        input logic br_lt);
    return f3[2] ? (br_lt ^ f3[0]) : (br_eq ^ f3[0]);
  endfunction

  // SUB only exists in register form; ADDI with funct7-like bits set stays ADD.
  function automatic ALUSel_t alu_from_funct(input funct3_t f3, input logic alt,
                                             input logic reg_form);
    case (f3)
      3'b000:  return (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_exec_decode.sv
// Combinational RV32I decode of opcode/funct fields into the EXEC-phase datapath
// selects (immediate format, ALU operand sources, ALU operation, branch signedness).
module mc_exec_decode
  import rv32_pkg::*;
(
  input  opcode_t    i_opcode,
  input  funct3_t    i_funct3,
  input  logic [6:0] i_funct7,
  output ImmSel_t    o_imm_sel,
  output logic       o_a_sel,
  output logic       o_b_sel,
  output ALUSel_t    o_alu_sel,
  output logic       o_br_un
);

  logic w_alt;

  // Only the exact 0100000 pattern selects SUB/SRA.
  assign w_alt = (i_funct7 == 7'b0100000);

  always_comb begin
    o_imm_sel = IMM_I;
    o_a_sel   = 1'b0;
    o_b_sel   = 1'b0;
    o_alu_sel = ALU_ADD;
    o_br_un   = 1'b0;
    case (i_opcode)
      OPC_OP: begin
        o_alu_sel = alu_from_funct(i_funct3, w_alt, 1'b1);
      end
      OPC_OP_IMM: begin
        o_b_sel   = 1'b1;
        o_alu_sel = alu_from_funct(i_funct3, w_alt, 1'b0);
      end
      OPC_LOAD, OPC_JALR: begin
        o_b_sel = 1'b1;
      end
      OPC_STORE: begin
        o_imm_sel = IMM_S;
        o_b_sel   = 1'b1;
      end
      OPC_BRANCH: begin
        o_imm_sel = IMM_B;
        o_a_sel   = 1'b1;
        o_b_sel   = 1'b1;
        o_br_un   = i_funct3[1];
      end
      OPC_JAL: begin
        o_imm_sel = IMM_J;
        o_a_sel   = 1'b1;
        o_b_sel   = 1'b1;
      end
      OPC_LUI: begin
        o_imm_sel = IMM_U;
        o_b_sel   = 1'b1;
        o_alu_sel = ALU_LUI;
      end
      OPC_AUIPC: begin
        o_imm_sel = IMM_U;
        o_a_sel   = 1'b1;
        o_b_sel   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout.
// Define MC_ILLEGAL_TRAP_EN to halt on unrecognised opcodes instead of retiring them as NOPs.
module mc_control_fsm
  import rv32_pkg::*;
#(
  parameter int MEM_TO_CYCLES = MC_TO_DEFAULT
)(
  input  logic       clk,
  input  logic       rst,
  input  opcode_t    opcode,
  input  funct3_t    funct3,
  input  logic [6:0] funct7,
  input  logic       BrEq,
  input  logic       BrLT,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       AddrSel,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       PCWrite,
  output logic       RegWEn,
  output PCSel_t     PCSel,
  output ImmSel_t    ImmSel,
  output logic       BrUn,
  output logic       ASel,
  output logic       BSel,
  output ALUSel_t    ALUSel,
  output WBSel_t     WBSel,
  output logic       instr_retired,
  output logic       mem_err,
  output logic       illegal_instr,
  output mc_state_t  state_o
);

  localparam int CNT_NEED = $clog2(MEM_TO_CYCLES + 1);
  localparam int CW       = (CNT_NEED > MC_CNT_MIN_W) ? CNT_NEED : MC_CNT_MIN_W;

  mc_state_t     r_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_mem_err;

  logic          w_legal;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_is_branch;
  logic          w_is_jump;
  logic          w_taken;
  logic [CW-1:0] w_to_last;

  ImmSel_t       w_dec_imm;
  logic          w_dec_a;
  logic          w_dec_b;
  ALUSel_t       w_dec_alu;
  logic          w_dec_br_un;

  assign w_legal     = is_legal_opcode(opcode);
  assign w_is_load   = (opcode == OPC_LOAD);
  assign w_is_store  = (opcode == OPC_STORE);
  assign w_is_branch = (opcode == OPC_BRANCH);
  assign w_is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign w_taken     = branch_taken(funct3, BrEq, BrLT);
  // Timeout fires on the wait cycle that would bring the counter to MEM_TO_CYCLES.
  assign w_to_last   = CW'(MEM_TO_CYCLES - 1);

  mc_exec_decode u_exec_decode (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .o_imm_sel (w_dec_imm),
    .o_a_sel   (w_dec_a),
    .o_b_sel   (w_dec_b),
    .o_alu_sel (w_dec_alu),
    .o_br_un   (w_dec_br_un)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign illegal_instr = r_illegal;
`else
  assign illegal_instr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_wait_cnt <= '0;
            r_state    <= S_DECODE;
          end else if (r_wait_cnt == w_to_last) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            r_mem_err  <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
`ifdef MC_ILLEGAL_TRAP_EN
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_state   <= S_EXEC;
          end
`else
          r_state <= S_EXEC;
`endif
        end
        S_EXEC: begin
          if (!w_legal || w_is_branch) begin
            r_wait_cnt <= '0;
            r_state    <= S_FETCH;
          end else if (w_is_load || w_is_store) begin
            r_wait_cnt <= '0;
            r_state    <= S_MEM;
          end else begin
            r_state    <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait_cnt <= '0;
            r_state    <= w_is_store ? S_FETCH : S_WB;
          end else if (r_wait_cnt == w_to_last) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            r_mem_err  <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          r_wait_cnt <= '0;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_wait_cnt <= '0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  // Enables depend on mem_ready in the same cycle; rst masks them so an
  // aborted access never sees a write strobe.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    AddrSel       = 1'b0;
    IRWrite       = 1'b0;
    MDRWrite      = 1'b0;
    PCWrite       = 1'b0;
    RegWEn        = 1'b0;
    instr_retired = 1'b0;
    PCSel         = PC_PC4;
    ImmSel        = IMM_I;
    BrUn          = 1'b0;
    ASel          = 1'b0;
    BSel          = 1'b0;
    ALUSel        = ALU_ADD;
    WBSel         = WB_ALU;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
        end
        S_EXEC: begin
          ImmSel = w_dec_imm;
          ASel   = w_dec_a;
          BSel   = w_dec_b;
          ALUSel = w_dec_alu;
          BrUn   = w_dec_br_un;
          if (!w_legal || w_is_branch) begin
            PCWrite       = 1'b1;
            instr_retired = 1'b1;
            PCSel         = (w_legal && w_taken) ? PC_ALU : PC_PC4;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          AddrSel = 1'b1;
          mem_we  = w_is_store;
          if (mem_ready) begin
            if (w_is_store) begin
              PCWrite       = 1'b1;
              instr_retired = 1'b1;
            end else begin
              MDRWrite = 1'b1;
            end
          end
        end
        S_WB: begin
          RegWEn        = 1'b1;
          PCWrite       = 1'b1;
          instr_retired = 1'b1;
          if (w_is_load)      WBSel = WB_MEM;
          else if (w_is_jump) WBSel = WB_PC4;
          PCSel = w_is_jump ? PC_ALU : PC_PC4;
        end
        default: ;
      endcase
    end
  end

  assign mem_err = r_mem_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: checks per-cycle state, enables and selects
// against hand-computed values; bench memory drives mem_ready directly.
module tb_mc_control_fsm;
  import rv32_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  opcode_t    opcode = OPC_OP_IMM;
  funct3_t    funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0;
  logic       BrEq = 1'b0;
  logic       BrLT = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_we, AddrSel, IRWrite, MDRWrite, PCWrite, RegWEn;
  PCSel_t     PCSel;
  ImmSel_t    ImmSel;
  logic       BrUn, ASel, BSel;
  ALUSel_t    ALUSel;
  WBSel_t     WBSel;
  logic       instr_retired, mem_err, illegal_instr;
  mc_state_t  state_o;

  // {mem_req, mem_we, AddrSel, IRWrite, MDRWrite, PCWrite, RegWEn, instr_retired}
  logic [7:0] en;
  assign en = {mem_req, mem_we, AddrSel, IRWrite, MDRWrite, PCWrite, RegWEn, instr_retired};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TO_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .AddrSel(AddrSel), .IRWrite(IRWrite),
    .MDRWrite(MDRWrite), .PCWrite(PCWrite), .RegWEn(RegWEn), .PCSel(PCSel),
    .ImmSel(ImmSel), .BrUn(BrUn), .ASel(ASel), .BSel(BSel), .ALUSel(ALUSel),
    .WBSel(WBSel), .instr_retired(instr_retired), .mem_err(mem_err),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From an S_FETCH cycle: hold mem_ready low for 'waits' cycles, then complete.
  // Returns one tick into S_DECODE.
  task automatic fetch_ready(input int waits);
    mem_ready = 1'b0;
    repeat (waits) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (state_o !== S_FETCH) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", state_o, S_FETCH); end
    n_checks++; if (en !== 8'h00) begin n_errors++; $display("FAIL reset_enables: got %b want %b", en, 8'h00); end
    n_checks++; if ({mem_err, illegal_instr} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b want 00", {mem_err, illegal_instr}); end
    n_checks++; if (PCSel !== PC_PC4 || ImmSel !== IMM_I || ALUSel !== ALU_ADD || WBSel !== WB_ALU || {BrUn, ASel, BSel} !== 3'b000) begin
      n_errors++; $display("FAIL reset_selects: got pc=%0d imm=%0d alu=%0d wb=%0d bau=%b", PCSel, ImmSel, ALUSel, WBSel, {BrUn, ASel, BSel});
    end
    rst = 1'b0;
    #1;
    n_checks++; if (en !== 8'b1000_0000) begin n_errors++; $display("FAIL fetch_after_reset: got %b want %b", en, 8'b1000_0000); end
  endtask

  task automatic test_addi();
    opcode = OPC_OP_IMM; funct3 = 3'b000; funct7 = 7'h00; mem_ready = 1'b0;
    #1;
    for (int c = 1; c <= 2; c++) begin
      n_checks++; if (state_o !== S_FETCH || en !== 8'b1000_0000) begin n_errors++; $display("FAIL addi_fetch_wait%0d: got st=%0d en=%b want st=0 en=10000000", c, state_o, en); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (en !== 8'b1001_0000) begin n_errors++; $display("FAIL addi_irwrite_c3: got %b want %b", en, 8'b1001_0000); end
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state_o !== S_DECODE || en !== 8'h00) begin n_errors++; $display("FAIL addi_decode: got st=%0d en=%b want st=1 en=0", state_o, en); end
    tick();
    n_checks++; if (state_o !== S_EXEC || en !== 8'h00 || ImmSel !== IMM_I || BSel !== 1'b1 || ASel !== 1'b0 || ALUSel !== ALU_ADD) begin
      n_errors++; $display("FAIL addi_exec: got st=%0d en=%b imm=%0d a=%b b=%b alu=%0d", state_o, en, ImmSel, ASel, BSel, ALUSel);
    end
    tick();
    n_checks++; if (state_o !== S_WB || en !== 8'b0000_0111 || PCSel !== PC_PC4 || WBSel !== WB_ALU) begin
      n_errors++; $display("FAIL addi_wb: got st=%0d en=%b pc=%0d wb=%0d want st=4 en=00000111 pc=0 wb=1", state_o, en, PCSel, WBSel);
    end
    tick();
    n_checks++; if (state_o !== S_FETCH) begin n_errors++; $display("FAIL addi_return: got %0d want %0d", state_o, S_FETCH); end
  endtask

  task automatic test_lw();
    opcode = OPC_LOAD; funct3 = 3'b010; funct7 = 7'h00;
    mem_ready = 1'b1;
    #1;
    n_checks++; if (state_o !== S_FETCH || en !== 8'b1001_0000) begin n_errors++; $display("FAIL lw_fetch: got st=%0d en=%b", state_o, en); end
    tick();
    // mem_ready left high through DECODE/EXEC must have no effect
    n_checks++; if (state_o !== S_DECODE || en !== 8'h00) begin n_errors++; $display("FAIL lw_decode_ignore_ready: got st=%0d en=%b", state_o, en); end
    tick();
    n_checks++; if (state_o !== S_EXEC || en !== 8'h00 || ImmSel !== IMM_I || BSel !== 1'b1) begin n_errors++; $display("FAIL lw_exec: got st=%0d en=%b imm=%0d b=%b", state_o, en, ImmSel, BSel); end
    tick();
    n_checks++; if (state_o !== S_MEM || en !== 8'b1010_1000) begin n_errors++; $display("FAIL lw_mem: got st=%0d en=%b want st=3 en=10101000", state_o, en); end
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state_o !== S_WB || en !== 8'b0000_0111 || WBSel !== WB_MEM || PCSel !== PC_PC4) begin n_errors++; $display("FAIL lw_wb: got st=%0d en=%b wb=%0d pc=%0d", state_o, en, WBSel, PCSel); end
    tick();
    n_checks++; if (state_o !== S_FETCH) begin n_errors++; $display("FAIL lw_five_cycles: got %0d want %0d", state_o, S_FETCH); end
  endtask

  task automatic test_branches();
    funct3_t f3_t[6]   = '{3'b111, 3'b000, 3'b001, 3'b100, 3'b110, 3'b101};
    logic    eq_t[6]   = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1};
    logic    lt_t[6]   = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
    PCSel_t  pc_t[6]   = '{PC_PC4, PC_ALU, PC_PC4, PC_ALU, PC_PC4, PC_ALU};
    logic    un_t[6]   = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
    for (int i = 0; i < 6; i++) begin
      opcode = OPC_BRANCH; funct3 = f3_t[i]; funct7 = 7'h00;
      BrEq = eq_t[i]; BrLT = lt_t[i];
      fetch_ready(0);
      tick();
      n_checks++; if (state_o !== S_EXEC || en !== 8'b0000_0101 || PCSel !== pc_t[i] || BrUn !== un_t[i] || ImmSel !== IMM_B || ASel !== 1'b1) begin
        n_errors++; $display("FAIL branch%0d_exec: got st=%0d en=%b pc=%0d un=%b imm=%0d a=%b want pc=%0d un=%b", i, state_o, en, PCSel, BrUn, ImmSel, ASel, pc_t[i], un_t[i]);
      end
      tick();
      n_checks++; if (state_o !== S_FETCH) begin n_errors++; $display("FAIL branch%0d_return: got %0d want 0", i, state_o); end
    end
    BrEq = 1'b0; BrLT = 1'b0;
  endtask

  task automatic test_decode_table();
    opcode_t    op_t[6]  = '{OPC_OP,  OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    funct3_t    f3_t[6]  = '{3'b000,  3'b101,     3'b000,  3'b000,    3'b000,  3'b000};
    logic [6:0] f7_t[6]  = '{7'h20,   7'h20,      7'h00,   7'h00,     7'h00,   7'h00};
    logic       ci_t[6]  = '{1'b0,    1'b1,       1'b1,    1'b1,      1'b1,    1'b1};
    ImmSel_t    im_t[6]  = '{IMM_I,   IMM_I,      IMM_U,   IMM_U,     IMM_J,   IMM_I};
    logic       a_t[6]   = '{1'b0,    1'b0,       1'b0,    1'b1,      1'b1,    1'b0};
    logic       b_t[6]   = '{1'b0,    1'b1,       1'b1,    1'b1,      1'b1,    1'b1};
    ALUSel_t    al_t[6]  = '{ALU_SUB, ALU_SRA,    ALU_LUI, ALU_ADD,   ALU_ADD, ALU_ADD};
    WBSel_t     wb_t[6]  = '{WB_ALU,  WB_ALU,     WB_ALU,  WB_ALU,    WB_PC4,  WB_PC4};
    PCSel_t     pc_t[6]  = '{PC_PC4,  PC_PC4,     PC_PC4,  PC_PC4,    PC_ALU,  PC_ALU};
    for (int i = 0; i < 6; i++) begin
      opcode = op_t[i]; funct3 = f3_t[i]; funct7 = f7_t[i];
      fetch_ready(1);
      tick();
      n_checks++; if (state_o !== S_EXEC || en !== 8'h00 || ASel !== a_t[i] || BSel !== b_t[i] || ALUSel !== al_t[i] || (ci_t[i] && ImmSel !== im_t[i])) begin
        n_errors++; $display("FAIL dec%0d_exec: got st=%0d en=%b a=%b b=%b alu=%0d imm=%0d want a=%b b=%b alu=%0d imm=%0d", i, state_o, en, ASel, BSel, ALUSel, ImmSel, a_t[i], b_t[i], al_t[i], im_t[i]);
      end
      tick();
      n_checks++; if (state_o !== S_WB || en !== 8'b0000_0111 || WBSel !== wb_t[i] || PCSel !== pc_t[i]) begin
        n_errors++; $display("FAIL dec%0d_wb: got st=%0d en=%b wb=%0d pc=%0d want wb=%0d pc=%0d", i, state_o, en, WBSel, PCSel, wb_t[i], pc_t[i]);
      end
      tick();
    end
  endtask

  // mem_ready arrives on the last wait cycle before timeout: completion wins.
  task automatic test_store_boundary();
    opcode = OPC_STORE; funct3 = 3'b010; funct7 = 7'h00;
    fetch_ready(0);
    tick();
    n_checks++; if (state_o !== S_EXEC || ImmSel !== IMM_S || BSel !== 1'b1 || en !== 8'h00) begin n_errors++; $display("FAIL sw_exec: got st=%0d imm=%0d b=%b en=%b", state_o, ImmSel, BSel, en); end
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (state_o !== S_MEM || en !== 8'b1110_0000) begin n_errors++; $display("FAIL sw_mem_wait%0d: got st=%0d en=%b want st=3 en=11100000", c, state_o, en); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (state_o !== S_MEM || en !== 8'b1110_0101 || PCSel !== PC_PC4) begin n_errors++; $display("FAIL sw_ready_at_limit: got st=%0d en=%b pc=%0d", state_o, en, PCSel); end
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state_o !== S_FETCH || mem_err !== 1'b0) begin n_errors++; $display("FAIL sw_no_err: got st=%0d err=%b want st=0 err=0", state_o, mem_err); end
  endtask

  task automatic test_timeout();
    opcode = OPC_STORE; funct3 = 3'b010; funct7 = 7'h00;
    fetch_ready(0);
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (state_o !== S_MEM || en !== 8'b1110_0000 || mem_err !== 1'b0) begin n_errors++; $display("FAIL to_wait%0d: got st=%0d en=%b err=%b", c, state_o, en, mem_err); end
      tick();
    end
    n_checks++; if (state_o !== S_HALT || mem_err !== 1'b1 || en !== 8'h00) begin n_errors++; $display("FAIL to_halt: got st=%0d err=%b en=%b want st=5 err=1 en=0", state_o, mem_err, en); end
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (state_o !== S_HALT || en !== 8'h00 || mem_err !== 1'b1) begin n_errors++; $display("FAIL halt_hold%0d: got st=%0d en=%b err=%b", c, state_o, en, mem_err); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_rst_mid_store();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (state_o !== S_FETCH || mem_err !== 1'b0) begin n_errors++; $display("FAIL rst_clears_err: got st=%0d err=%b", state_o, mem_err); end
    opcode = OPC_STORE; funct3 = 3'b010; funct7 = 7'h00;
    fetch_ready(0);
    tick();
    tick();
    n_checks++; if (state_o !== S_MEM || en !== 8'b1110_0000) begin n_errors++; $display("FAIL rst_pre_mem: got st=%0d en=%b", state_o, en); end
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_checks++; if (en !== 8'h00) begin n_errors++; $display("FAIL rst_abort_no_we: got %b want 00000000", en); end
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state_o !== S_FETCH || en !== 8'b1000_0000 || {mem_err, illegal_instr} !== 2'b00) begin
      n_errors++; $display("FAIL rst_after_abort: got st=%0d en=%b flags=%b want st=0 en=10000000 flags=00", state_o, en, {mem_err, illegal_instr});
    end
  endtask

  task automatic test_illegal();
    opcode = opcode_t'(7'h7F); funct3 = 3'b000; funct7 = 7'h00;
    fetch_ready(0);
    n_checks++; if (state_o !== S_DECODE || en !== 8'h00) begin n_errors++; $display("FAIL ill_decode: got st=%0d en=%b", state_o, en); end
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    n_checks++; if (state_o !== S_HALT || illegal_instr !== 1'b1 || en !== 8'h00) begin n_errors++; $display("FAIL ill_trap: got st=%0d ill=%b en=%b want st=5 ill=1 en=0", state_o, illegal_instr, en); end
    tick();
    n_checks++; if (state_o !== S_HALT || illegal_instr !== 1'b1) begin n_errors++; $display("FAIL ill_trap_hold: got st=%0d ill=%b", state_o, illegal_instr); end
`else
    n_checks++; if (state_o !== S_EXEC || en !== 8'b0000_0101 || PCSel !== PC_PC4 || illegal_instr !== 1'b0) begin
      n_errors++; $display("FAIL ill_nop_exec: got st=%0d en=%b pc=%0d ill=%b want st=2 en=00000101 pc=0 ill=0", state_o, en, PCSel, illegal_instr);
    end
    tick();
    n_checks++; if (state_o !== S_FETCH || illegal_instr !== 1'b0) begin n_errors++; $display("FAIL ill_nop_return: got st=%0d ill=%b", state_o, illegal_instr); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_branches();
    test_decode_table();
    test_store_boundary();
    test_timeout();
    test_rst_mid_store();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_TO_CYCLES, default 255: wait cycles with mem_req=1 and mem_ready=0 before timeout.
REQ-002 clk  in  1  rising-edge clock; reset is synchronous and active-high.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 opcode/funct3/funct7  in  opcode_t/funct3_t/7  fields from the datapath instruction register (IR).
REQ-005 BrEq, BrLT  in  1 each  branch comparator results.
REQ-006 mem_ready  in  1  unified memory access complete; read data valid this cycle.
REQ-007 mem_req, mem_we, AddrSel  out  1 each  memory request; write (store); address select (0=PC, 1=ALUOut).
REQ-008 IRWrite, MDRWrite, PCWrite, RegWEn  out  1 each  register load enables.
REQ-009 PCSel, ImmSel, BrUn, ASel, BSel, ALUSel, WBSel  out  datapath selects, rv32_pkg enum types.
REQ-010 instr_retired  out  1  one-cycle pulse per completed instruction.
REQ-011 mem_err, illegal_instr  out  1 each  sticky error flags.
REQ-012 state_o  out  mc_state_t  current state.

Function
REQ-013 States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT.
REQ-014 S_FETCH: mem_req=1, AddrSel=0, mem_we=0; hold until mem_ready; on mem_ready, IRWrite=1 and next state is S_DECODE.
REQ-015 S_DECODE: one cycle, no enables; next state is S_EXEC.
REQ-016 S_EXEC: drive ImmSel/ASel/BSel/ALUSel/BrUn from the RV32I decode table (R: regs, ALU from funct3/funct7[5]; I-ALU/LOAD/JALR: Imm_I, BSel=1; S: Imm_S; B: Imm_B, ASel=1, ALU_ADD, BrUn=funct3[1]; JAL: Imm_J, ASel=1; LUI: Imm_U, ALU_LUI; AUIPC: Imm_U, ASel=1).
REQ-017 S_EXEC branch: PCWrite=1, instr_retired=1, next S_FETCH; PCSel=PC_ALU iff taken (BEQ BrEq, BNE !BrEq, BLT/BLTU BrLT, BGE/BGEU !BrLT), else PC_PC4.
REQ-018 S_EXEC load/store: next S_MEM; all other legal opcodes: next S_WB.
REQ-019 S_MEM: mem_req=1, AddrSel=1, mem_we=1 for stores only; hold until mem_ready.
REQ-020 S_MEM on mem_ready: store -> PCWrite=1, PCSel=PC_PC4, instr_retired=1, next S_FETCH; load -> MDRWrite=1, next S_WB.
REQ-021 S_WB: RegWEn=1, PCWrite=1, instr_retired=1, next S_FETCH; WBSel=WB_MEM (load), WB_PC4 (JAL/JALR), else WB_ALU; PCSel=PC_ALU for JAL/JALR, else PC_PC4.
REQ-022 Outside the listed conditions all enables (mem_req, mem_we, IRWrite, MDRWrite, PCWrite, RegWEn, instr_retired) SHALL be 0.
REQ-023 Latency: branch/JAL-free ALU op 4 cycles plus fetch wait; load 5 plus two memory waits; store 4 plus two memory waits.
REQ-024 Wait counter: 8-bit min, cleared on entry to S_FETCH/S_MEM and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
REQ-025 Counter reaching MEM_TO_CYCLES with mem_ready=0: mem_err set, next S_HALT; mem_ready in that same cycle takes priority (normal completion, no error).
REQ-026 S_HALT: all enables 0; remains until rst.
REQ-027 mem_ready outside S_FETCH/S_MEM SHALL be ignored.

Reset
REQ-028 rst (sync, high) SHALL force S_FETCH, counter 0, mem_err=0, illegal_instr=0, all enables 0, selects to PC_PC4/Imm_I/ALU_ADD/WB_ALU/0; rst mid-access aborts it with no write enable pulsed.

Configuration
REQ-029 Macro MC_ILLEGAL_TRAP_EN defined: unrecognised opcode in S_DECODE sets illegal_instr and goes to S_HALT.
REQ-030 Macro undefined: unrecognised opcode retires as NOP (S_DECODE -> S_EXEC with PCWrite=1, PC_PC4, instr_retired=1 -> S_FETCH); illegal_instr tied 0.

Structure
REQ-031 mc_state_t and MC_TO_DEFAULT constant SHALL live in rv32_pkg alongside opcode_t/PCSel_t/ImmSel_t/ALUSel_t/WBSel_t.
REQ-032 One sub-module, mc_exec_decode (combinational opcode/funct -> EXEC selects), reusing the single-cycle decode table.

Verification
REQ-033 ADDI, mem_ready after 2 waits in fetch -> IRWrite pulse cycle 3, RegWEn+PCWrite(PC_PC4)+instr_retired in S_WB, WBSel=WB_ALU.
REQ-034 LW, mem_ready=1 immediately both phases -> states F,D,E,M,W; MDRWrite in S_MEM; RegWEn with WB_MEM; 5 cycles total.
REQ-035 BGEU BrEq=0 BrLT=1 -> BrUn=1, PCSel=PC_PC4, retire in S_EXEC; BEQ BrEq=1 -> PCSel=PC_ALU.
REQ-036 SW with mem_ready held 0 in S_MEM, MEM_TO_CYCLES=4 -> mem_err=1, S_HALT after 4 wait cycles, mem_we never 1 afterwards.
REQ-037 Opcode 7'h7F: with MC_ILLEGAL_TRAP_EN -> illegal_instr=1, S_HALT; without -> NOP retire, PC_PC4, back to S_FETCH.
REQ-038 rst asserted during S_MEM store -> next cycle S_FETCH, mem_req=1, mem_we=0, flags cleared.
